snake_game_sequencer: RTL and testbench
=======================================

# snake_game_sequencer

Game-level controller for the two-player snake design. It divides the VGA frame rate into game ticks and grants the shared grid update datapath to snake 0, then snake 1, using a go/done handshake. It evaluates the renderer's collision flags and apple events once per tick, and runs the IDLE/RUN/PAUSE/OVER game flow. It sits between the VGA timing/render block (which supplies `frame_start` and hit flags) and the two snake movement engines.

## Interface
- `FRAMES_PER_TICK`, default 8: VGA frames per game tick. Legal range 1..255.
- `MOVE_TIMEOUT`, default 1023: maximum clk cycles to wait for a `move_done`. Legal range 1..65535.
- `clk`  in  1: system clock.
- `rst`  in  1: reset, asynchronous, active-low.
- `frame_start`  in  1: one-cycle pulse per frame (vsync falling edge), synchronous to clk.
- `start_btn`  in  1: synchronised level; the rising edge is detected internally.
- `pause_sw`  in  1: synchronised level; high requests pause.
- `move_done`  in  2: per-snake one-cycle acknowledge from the movement engines.
- `hit_in`  in  2: bit i high means snake i crashed (level, held for the frame).
- `apple_eaten`  in  2: bit i high means snake i's head is on the apple (level).
- `move_go`  out  2: one-hot, one-cycle grant to a movement engine.
- `apple_respawn`  out  1: one-cycle request for a new apple position.
- `game_state`  out  3: current FSM state encoding.
- `winner`  out  2: 01 = snake 0, 10 = snake 1, 11 = draw, 00 = none.
- `score0`, `score1`  out  8 each: apples eaten per snake, saturating at 255.
- `err`  out  2: sticky flags. Bit 0 = move timeout, bit 1 = tick overrun.

## Operation
- FSM encodings:
  - IDLE = 0, WAIT = 1, MOVE0 = 2, MOVE1 = 3, CHECK = 4, PAUSE = 5, OVER = 6.
- **IDLE**
  - A `start_btn` rising edge goes to WAIT and clears scores, `winner`, `err`, the frame counter and `tick_pend`.
- **Frame divider**
  - Counts `frame_start` pulses in WAIT, MOVE0, MOVE1 and CHECK.
  - On reaching `FRAMES_PER_TICK`, the counter reloads to 0 and `tick_pend` is set.
  - If `tick_pend` is already set at that moment, the new tick is dropped and `err[1]` is set.
  - The counter is frozen in IDLE, PAUSE and OVER.
- **WAIT**
  - `pause_sw` high goes to PAUSE. Pause takes priority over a pending tick.
  - Otherwise, if `tick_pend` is set: clear `tick_pend`, pulse `move_go = 01`, go to MOVE0.
- **MOVE0**
  - On `move_done[0]`, or when the timeout counter reaches `MOVE_TIMEOUT` (this also sets `err[0]`): pulse `move_go = 10`, go to MOVE1.
  - `move_done[1]` is ignored in this state.
- **MOVE1**
  - Same as MOVE0 for `move_done[1]`; the exit goes to CHECK.
  - The timeout counter clears on every state entry.
- **CHECK** (exactly one cycle)
  - `hit_in == 11`: `winner = 11`, go to OVER.
  - `hit_in == 01`: `winner = 10`, go to OVER.
  - `hit_in == 10`: `winner = 01`, go to OVER.
  - Otherwise, for each `apple_eaten` bit set, increment the matching score (saturating). If any bit is set, pulse `apple_respawn` once even when both bits are set. Then go to WAIT.
  - Hits take precedence over apples: no score change and no respawn on a game-over tick.
- **PAUSE**
  - `pause_sw` low returns to WAIT. `tick_pend` is preserved.
- **OVER**
  - Outputs are held.
  - A `start_btn` rising edge goes to WAIT with the same clears as IDLE.
- **Start edge detector**
  - The previous-value flop resets to 1, so a button held through reset does not start a game.
- **Reset**
  - Asynchronous at any point, including mid-handshake.
  - All outputs go to 0 and `game_state` goes to IDLE.
  - Any in-flight grant is abandoned.

## Timing
- All outputs are registered.
- `move_go[0]` rises on the cycle after the clock edge where WAIT sees `tick_pend`.
  - Worst case: 2 cycles from the tick-completing `frame_start`.
- `move_done` is sampled from the first cycle in a MOVE state onward, so it may arrive on the cycle right after `move_go`.
  - A done in the same cycle as the go pulse is not visible.
- Minimum tick latency from WAIT to return to WAIT is 5 cycles: WAIT, MOVE0, MOVE1, CHECK, WAIT.
- `apple_respawn` and score updates appear on the cycle after CHECK.
- `move_go` and `apple_respawn` are never high for more than one cycle.

## Structure
- Shared package `snake_pkg` holds:
  - FSM state encodings;
  - winner codes;
  - grid cell codes NONE/HEAD/BODY/WALL = 00/01/10/11, shared with the renderer.
- One sub-module, `snake_tick_divider`, contains the frame counter, `tick_pend` and overrun detect.
  - Its ports are `enable`, `clear`, `frame_start` and `tick_ack`.
  - Its outputs are `tick_pend` and `overrun`.

## Test plan
- **Normal ticks:** `FRAMES_PER_TICK = 2`, engines ack 3 cycles after go.
  - 6 frames produce exactly 3 `move_go` sequences, each ordered 01 then 10.
- **Apple events:** `apple_eaten = 11` in one tick.
  - Required: `score0 = score1 = 1`, one `apple_respawn` pulse.
  - 256 solo eats by snake 0 leave `score0 = 255`.
- **Collisions:** `hit_in = 01` together with `apple_eaten = 01`.
  - Required: `winner = 10`, state OVER, `score0` unchanged, no respawn.
  - With `hit_in = 11`: `winner = 11`.
- **Timeout and overrun:** `MOVE_TIMEOUT = 10`, `move_done[0]` never arrives.
  - Required: `move_go = 10` exactly 10 cycles after entering MOVE0, and `err[0] = 1`.
  - A second tick completing while `tick_pend = 1` sets `err[1]`.
- **Pause:** `pause_sw` high while `tick_pend = 1`.
  - Required: no `move_go` during pause, frame counter frozen.
  - On release: `move_go = 01` within 2 cycles.
- **Reset and start edge:** reset asserted mid-MOVE1.
  - Required: all outputs 0, state IDLE.
  - `start_btn` held high across reset release gives no start; a low-then-high transition starts the game.

Source files
------------

// File: rtl/snake_pkg.sv
// Shared definitions for the two-player snake design: game FSM encodings,
// winner codes, grid cell codes and a saturating score helper.
package snake_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WAIT  = 3'd1,
    ST_MOVE0 = 3'd2,
    ST_MOVE1 = 3'd3,
    ST_CHECK = 3'd4,
    ST_PAUSE = 3'd5,
    ST_OVER  = 3'd6
  } game_state_e;

  localparam logic [1:0] WIN_NONE   = 2'b00;
  localparam logic [1:0] WIN_SNAKE0 = 2'b01;
  localparam logic [1:0] WIN_SNAKE1 = 2'b10;
  localparam logic [1:0] WIN_DRAW   = 2'b11;

  // Grid cell codes, shared with the renderer.
  typedef enum logic [1:0] {
    CELL_NONE = 2'b00,
    CELL_HEAD = 2'b01,
    CELL_BODY = 2'b10,
    CELL_WALL = 2'b11
  } cell_e;

  function automatic logic [7:0] sat_inc8(input logic [7:0] value);
    if (value == 8'hFF) begin
      return value;
    end else begin
      return value + 8'd1;
    end
  endfunction

endpackage

// File: rtl/snake_tick_divider.sv
// Frame-to-tick divider: counts frame_start pulses while enabled, raises
// tick_pend every FRAMES_PER_TICK frames and flags a tick dropped on overrun.
module snake_tick_divider
  import snake_pkg::*;
#(
  parameter int unsigned FRAMES_PER_TICK = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic clear,
  input  logic frame_start,
  input  logic tick_ack,
  output logic tick_pend,
  output logic overrun
);

  localparam logic [7:0] LAST_FRAME = 8'(FRAMES_PER_TICK - 1);

  logic [7:0] count_q, count_d;
  logic       pend_q, pend_d;

  // Next count / pending-tick; an ack and a new tick on the same edge leave one pending.
  always_comb begin
    count_d = count_q;
    pend_d  = pend_q;
    overrun = 1'b0;
    if (clear) begin
      count_d = 8'd0;
      pend_d  = 1'b0;
    end else begin
      if (tick_ack) begin
        pend_d = 1'b0;
      end else begin
        pend_d = pend_q;
      end
      if (enable && frame_start) begin
        if (count_q >= LAST_FRAME) begin
          count_d = 8'd0;
          if (pend_q && !tick_ack) begin
            overrun = 1'b1;
          end else begin
            pend_d = 1'b1;
          end
        end else begin
          count_d = count_q + 8'd1;
        end
      end else begin
        count_d = count_q;
      end
    end
  end

  // Counter and pending-tick registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= 8'd0;
      pend_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      pend_q  <= pend_d;
    end
  end

  assign tick_pend = pend_q;

endmodule

// File: rtl/snake_game_sequencer.sv
// Game-level controller: turns frame ticks into ordered move grants for the
// two snakes, scores apples, detects crashes and runs the game flow.
module snake_game_sequencer
  import snake_pkg::*;
#(
  parameter int unsigned FRAMES_PER_TICK = 8,
  parameter int unsigned MOVE_TIMEOUT    = 1023
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_start,
  input  logic       start_btn,
  input  logic       pause_sw,
  input  logic [1:0] move_done,
  input  logic [1:0] hit_in,
  input  logic [1:0] apple_eaten,
  output logic [1:0] move_go,
  output logic       apple_respawn,
  output logic [2:0] game_state,
  output logic [1:0] winner,
  output logic [7:0] score0,
  output logic [7:0] score1,
  output logic [1:0] err
);

  localparam logic [15:0] MOVE_LIMIT = 16'(MOVE_TIMEOUT);

  game_state_e state_q, state_d;
  logic [1:0]  move_go_q, move_go_d;
  logic        respawn_q, respawn_d;
  logic [1:0]  winner_q, winner_d;
  logic [7:0]  score0_q, score0_d;
  logic [7:0]  score1_q, score1_d;
  logic [1:0]  err_q, err_d;
  logic [15:0] tmo_q, tmo_d;
  logic        start_prev_q, start_prev_d;

  logic start_rise_s;
  logic div_enable_s;
  logic div_clear_s;
  logic tick_ack_s;
  logic tick_pend_s;
  logic overrun_s;

  assign start_rise_s = start_btn & ~start_prev_q;
  assign div_enable_s = (state_q == ST_WAIT) || (state_q == ST_MOVE0) ||
                        (state_q == ST_MOVE1) || (state_q == ST_CHECK);

  snake_tick_divider #(
    .FRAMES_PER_TICK(FRAMES_PER_TICK)
  ) u_tick_divider (
    .clk        (clk),
    .rst        (rst),
    .enable     (div_enable_s),
    .clear      (div_clear_s),
    .frame_start(frame_start),
    .tick_ack   (tick_ack_s),
    .tick_pend  (tick_pend_s),
    .overrun    (overrun_s)
  );

  // Game FSM next state and next values of all registered outputs.
  always_comb begin
    state_d      = state_q;
    move_go_d    = 2'b00;
    respawn_d    = 1'b0;
    winner_d     = winner_q;
    score0_d     = score0_q;
    score1_d     = score1_q;
    err_d        = err_q;
    tmo_d        = tmo_q;
    start_prev_d = start_btn;
    div_clear_s  = 1'b0;
    tick_ack_s   = 1'b0;

    if (overrun_s) begin
      err_d[1] = 1'b1;
    end else begin
      err_d[1] = err_q[1];
    end

    case (state_q)
      ST_IDLE, ST_OVER: begin
        if (start_rise_s) begin
          state_d     = ST_WAIT;
          score0_d    = 8'd0;
          score1_d    = 8'd0;
          winner_d    = WIN_NONE;
          err_d       = 2'b00;
          div_clear_s = 1'b1;
        end else begin
          state_d = state_q;
        end
      end
      ST_WAIT: begin
        if (pause_sw) begin
          state_d = ST_PAUSE;
        end else if (tick_pend_s) begin
          tick_ack_s = 1'b1;
          move_go_d  = 2'b01;
          tmo_d      = 16'd1;
          state_d    = ST_MOVE0;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_MOVE0: begin
        if (move_done[0] || (tmo_q == MOVE_LIMIT)) begin
          if (!move_done[0]) begin
            err_d[0] = 1'b1;
          end else begin
            err_d[0] = err_q[0];
          end
          move_go_d = 2'b10;
          tmo_d     = 16'd1;
          state_d   = ST_MOVE1;
        end else begin
          tmo_d = tmo_q + 16'd1;
        end
      end
      ST_MOVE1: begin
        if (move_done[1] || (tmo_q == MOVE_LIMIT)) begin
          if (!move_done[1]) begin
            err_d[0] = 1'b1;
          end else begin
            err_d[0] = err_q[0];
          end
          state_d = ST_CHECK;
        end else begin
          tmo_d = tmo_q + 16'd1;
        end
      end
      ST_CHECK: begin
        // Crashes win over apples: a game-over tick scores nothing.
        case (hit_in)
          2'b11: begin
            winner_d = WIN_DRAW;
            state_d  = ST_OVER;
          end
          2'b01: begin
            winner_d = WIN_SNAKE1;
            state_d  = ST_OVER;
          end
          2'b10: begin
            winner_d = WIN_SNAKE0;
            state_d  = ST_OVER;
          end
          default: begin
            if (apple_eaten[0]) begin
              score0_d = sat_inc8(score0_q);
            end else begin
              score0_d = score0_q;
            end
            if (apple_eaten[1]) begin
              score1_d = sat_inc8(score1_q);
            end else begin
              score1_d = score1_q;
            end
            respawn_d = |apple_eaten;
            state_d   = ST_WAIT;
          end
        endcase
      end
      ST_PAUSE: begin
        if (!pause_sw) begin
          state_d = ST_WAIT;
        end else begin
          state_d = ST_PAUSE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; the start history resets high so a held button is ignored.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      move_go_q    <= 2'b00;
      respawn_q    <= 1'b0;
      winner_q     <= WIN_NONE;
      score0_q     <= 8'd0;
      score1_q     <= 8'd0;
      err_q        <= 2'b00;
      tmo_q        <= 16'd0;
      start_prev_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      move_go_q    <= move_go_d;
      respawn_q    <= respawn_d;
      winner_q     <= winner_d;
      score0_q     <= score0_d;
      score1_q     <= score1_d;
      err_q        <= err_d;
      tmo_q        <= tmo_d;
      start_prev_q <= start_prev_d;
    end
  end

  assign move_go       = move_go_q;
  assign apple_respawn = respawn_q;
  assign game_state    = state_q;
  assign winner        = winner_q;
  assign score0        = score0_q;
  assign score1        = score1_q;
  assign err           = err_q;

endmodule

// File: tb/tb_snake_game_sequencer.sv
// Scoreboard bench for snake_game_sequencer: expected grant/respawn events are
// queued by the stimulus and popped by an independent output monitor.
module tb_snake_game_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       frame_start = 1'b0;
  logic       start_btn = 1'b0;
  logic       pause_sw = 1'b0;
  logic [1:0] move_done;
  logic [1:0] hit_in = 2'b00;
  logic [1:0] apple_eaten = 2'b00;
  logic [1:0] move_go;
  logic       apple_respawn;
  logic [2:0] game_state;
  logic [1:0] winner;
  logic [7:0] score0;
  logic [7:0] score1;
  logic [1:0] err;

  logic       done0 = 1'b0;
  logic       done1 = 1'b0;
  logic [1:0] ack_en = 2'b11;
  logic [3:0] exp_q[$];
  int         vectors = 0;
  int         miscompares = 0;
  int         cyc = 0;
  int         go0_cyc = 0;
  int         go1_cyc = 0;
  int         rel_cyc = 0;
  logic       found;

  assign move_done = {done1, done0};

  snake_game_sequencer #(
    .FRAMES_PER_TICK(2),
    .MOVE_TIMEOUT   (10)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .frame_start  (frame_start),
    .start_btn    (start_btn),
    .pause_sw     (pause_sw),
    .move_done    (move_done),
    .hit_in       (hit_in),
    .apple_eaten  (apple_eaten),
    .move_go      (move_go),
    .apple_respawn(apple_respawn),
    .game_state   (game_state),
    .winner       (winner),
    .score0       (score0),
    .score1       (score1),
    .err          (err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Movement engines: acknowledge three cycles after seeing their grant.
  initial begin
    forever begin
      @(negedge clk);
      if (move_go[0] && ack_en[0]) begin
        repeat (3) @(posedge clk);
        #1 done0 = 1'b1;
        @(posedge clk);
        #1 done0 = 1'b0;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (move_go[1] && ack_en[1]) begin
        repeat (3) @(posedge clk);
        #1 done1 = 1'b1;
        @(posedge clk);
        #1 done1 = 1'b0;
      end
    end
  end

  // Monitor: every grant or respawn pulse pops one expected event.
  initial begin
    logic [3:0] e;
    forever begin
      @(negedge clk);
      if (move_go != 2'b00) begin
        if (move_go == 2'b01) go0_cyc = cyc;
        if (move_go == 2'b10) go1_cyc = cyc;
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_move_go actual=%b required=none at cycle %0d", move_go, cyc);
        end else begin
          e = exp_q.pop_front();
          if (e != {2'b00, move_go}) begin
            miscompares++;
            $display("FAIL event_order actual=%0h required=%0h at cycle %0d", {2'b00, move_go}, e, cyc);
          end
        end
      end
      if (apple_respawn) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_respawn actual=4 required=none at cycle %0d", cyc);
        end else begin
          e = exp_q.pop_front();
          if (e != 4'h4) begin
            miscompares++;
            $display("FAIL event_order actual=4 required=%0h at cycle %0d", e, cyc);
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic frame(input int gap);
    frame_start = 1'b1;
    cycles(1);
    frame_start = 1'b0;
    cycles(gap - 1);
  endtask

  task automatic run_tick(input bit resp);
    exp_q.push_back(4'h1);
    exp_q.push_back(4'h2);
    if (resp) exp_q.push_back(4'h4);
    frame(20);
    frame(20);
  endtask

  task automatic press_start();
    start_btn = 1'b0;
    cycles(2);
    start_btn = 1'b1;
    cycles(2);
    start_btn = 1'b0;
    cycles(1);
  endtask

  initial begin
    // Reset state, during and after reset.
    cycles(3);
    @(negedge clk);
    chk("rst_state", 16'(game_state), 16'd0);
    chk("rst_go", 16'(move_go), 16'd0);
    cycles(1);
    rst = 1'b1;
    cycles(2);
    @(negedge clk);
    chk("idle_state", 16'(game_state), 16'd0);
    chk("idle_outputs", 16'({winner, err, apple_respawn}), 16'd0);
    press_start();
    @(negedge clk);
    chk("start_wait", 16'(game_state), 16'd1);

    // Normal ticks: 6 frames, 3 ordered grant pairs.
    cycles(1);
    repeat (3) run_tick(1'b0);
    @(negedge clk);
    chk("normal_scores", 16'({score0, score1}), 16'd0);

    // Both snakes eat in one tick.
    cycles(1);
    apple_eaten = 2'b11;
    run_tick(1'b1);
    apple_eaten = 2'b00;
    @(negedge clk);
    chk("both_eat_s0", 16'(score0), 16'd1);
    chk("both_eat_s1", 16'(score1), 16'd1);

    // Solo eats by snake 0 up to saturation.
    cycles(1);
    apple_eaten = 2'b01;
    for (int i = 0; i < 253; i++) run_tick(1'b1);
    @(negedge clk);
    chk("solo_254", 16'(score0), 16'd254);
    cycles(1);
    for (int i = 0; i < 3; i++) run_tick(1'b1);
    apple_eaten = 2'b00;
    @(negedge clk);
    chk("solo_sat", 16'(score0), 16'd255);
    chk("solo_s1", 16'(score1), 16'd1);

    // Move timeout on snake 0.
    cycles(1);
    ack_en = 2'b10;
    run_tick(1'b0);
    @(negedge clk);
    chk("tmo_gap", 16'(go1_cyc - go0_cyc), 16'd10);
    chk("tmo_err", 16'(err), 16'd1);

    // Tick overrun with both engines silent and frames every 3 cycles.
    cycles(1);
    ack_en = 2'b00;
    repeat (4) exp_q.push_back(4'h1 + 4'(exp_q.size() % 2));
    repeat (6) frame(3);
    cycles(60);
    @(negedge clk);
    chk("overrun_err", 16'(err), 16'd3);
    ack_en = 2'b11;

    // Pause while a tick is pending.
    cycles(1);
    frame(20);
    pause_sw = 1'b1;
    frame(20);
    frame(20);
    @(negedge clk);
    chk("paused_state", 16'(game_state), 16'd5);
    exp_q.push_back(4'h1);
    exp_q.push_back(4'h2);
    @(posedge clk);
    #1;
    rel_cyc = cyc;
    pause_sw = 1'b0;
    cycles(20);
    chk("pause_release_lat", 16'(go0_cyc - rel_cyc), 16'd2);
    frame(20);
    run_tick(1'b0);
    @(negedge clk);
    chk("pause_frozen_drain", 16'(exp_q.size()), 16'd0);

    // Crash by snake 0 with an apple on the same tick.
    cycles(1);
    hit_in = 2'b01;
    apple_eaten = 2'b01;
    run_tick(1'b0);
    @(negedge clk);
    chk("hit01_state", 16'(game_state), 16'd6);
    chk("hit01_winner", 16'(winner), 16'd2);
    chk("hit01_score0", 16'(score0), 16'd255);
    cycles(1);
    hit_in = 2'b00;
    apple_eaten = 2'b00;
    frame(20);
    frame(20);
    @(negedge clk);
    chk("over_hold", 16'({game_state, winner}), 16'({3'd6, 2'b10}));
    cycles(1);
    press_start();
    @(negedge clk);
    chk("restart_clear", 16'({score0, score1}), 16'd0);
    chk("restart_flags", 16'({game_state, winner, err}), 16'({3'd1, 2'b00, 2'b00}));
    cycles(1);
    hit_in = 2'b11;
    run_tick(1'b0);
    hit_in = 2'b00;
    @(negedge clk);
    chk("hit11_winner", 16'(winner), 16'd3);
    chk("hit11_state", 16'(game_state), 16'd6);

    // Reset in the middle of MOVE1, then start-edge behaviour.
    cycles(1);
    press_start();
    apple_eaten = 2'b01;
    run_tick(1'b1);
    apple_eaten = 2'b00;
    ack_en = 2'b01;
    exp_q.push_back(4'h1);
    exp_q.push_back(4'h2);
    frame(20);
    frame_start = 1'b1;
    cycles(1);
    frame_start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (game_state == 3'd3) found = 1'b1;
    end
    chk("reach_move1", 16'(found), 16'd1);
    chk("pre_rst_score0", 16'(score0), 16'd1);
    @(negedge clk);
    start_btn = 1'b1;
    rst = 1'b0;
    #1;
    chk("midrst_state", 16'(game_state), 16'd0);
    chk("midrst_outs", 16'({move_go, apple_respawn, winner, err}), 16'd0);
    chk("midrst_scores", 16'({score0, score1}), 16'd0);
    cycles(3);
    rst = 1'b1;
    cycles(5);
    @(negedge clk);
    chk("held_btn_no_start", 16'(game_state), 16'd0);
    cycles(1);
    start_btn = 1'b0;
    cycles(2);
    start_btn = 1'b1;
    cycles(2);
    @(negedge clk);
    chk("edge_start", 16'(game_state), 16'd1);

    cycles(5);
    chk("queue_drained", 16'(exp_q.size()), 16'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
